// File: rtl/calculadora_decode.sv
// Fetch/decode front end for the calculator datapath: fetches one RV32I word per
// opera request, decodes OP-IMM / OP into RF indices, immediate and ALU op, pulses we.
module calculadora_decode #(
    parameter int W        = 64,
    parameter int A        = 8,
    parameter int PROG_LEN = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         opera,
    output logic [A-1:0] instr_addr,
    input  logic [31:0]  instr_data,
    output logic [4:0]   rs1,
    output logic [4:0]   rs2,
    output logic [4:0]   rd,
    output logic [W-1:0] imm,
    output logic         alu_src_imm,
    output logic [3:0]   alu_op,
    output logic         we,
    output logic         busy,
    output logic         illegal,
    output logic         done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9
    } alu_op_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // PC is modulo 2^A, so a program filling the whole ROM ends when PC wraps to 0.
    localparam logic [A-1:0] PC_END = A'(PROG_LEN);

    state_t       state;
    logic [A-1:0] pc;
    logic [A-1:0] pc_next;
    logic [31:0]  ir;

    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic [W-1:0] imm_i;
    logic [W-1:0] imm_shamt;

    logic         dec_legal;
    alu_op_t      dec_op;
    logic         dec_src_imm;
    logic [W-1:0] dec_imm;

    assign instr_addr = pc;
    assign pc_next    = pc + A'(1);

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign funct7    = ir[31:25];
    assign imm_i     = {{(W-12){ir[31]}}, ir[31:20]};
    assign imm_shamt = {{(W-5){1'b0}}, ir[24:20]};

    // Pure decode of IR; anything not explicitly matched falls out as illegal.
    always_comb begin
        dec_legal   = 1'b0;
        dec_op      = OP_ADD;
        dec_src_imm = 1'b0;
        dec_imm     = '0;
        case (opcode)
            OPC_OP_IMM: begin
                dec_src_imm = 1'b1;
                dec_imm     = imm_i;
                dec_legal   = 1'b1;
                case (funct3)
                    3'b000: dec_op = OP_ADD;
                    3'b010: dec_op = OP_SLT;
                    3'b011: dec_op = OP_SLTU;
                    3'b100: dec_op = OP_XOR;
                    3'b110: dec_op = OP_OR;
                    3'b111: dec_op = OP_AND;
                    3'b001: begin
                        dec_op    = OP_SLL;
                        dec_imm   = imm_shamt;
                        dec_legal = (funct7 == F7_BASE);
                    end
                    3'b101: begin
                        dec_imm = imm_shamt;
                        if (funct7 == F7_BASE) begin
                            dec_op = OP_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec_op = OP_SRA;
                        end else begin
                            dec_legal = 1'b0;
                        end
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000:  dec_op = OP_ADD;
                        3'b001:  dec_op = OP_SLL;
                        3'b010:  dec_op = OP_SLT;
                        3'b011:  dec_op = OP_SLTU;
                        3'b100:  dec_op = OP_XOR;
                        3'b101:  dec_op = OP_SRL;
                        3'b110:  dec_op = OP_OR;
                        default: dec_op = OP_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000) begin
                        dec_legal = 1'b1;
                        dec_op    = OP_SUB;
                    end else if (funct3 == 3'b101) begin
                        dec_legal = 1'b1;
                        dec_op    = OP_SRA;
                    end
                end
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Sequencer: busy and we are registered so they line up exactly with the
    // FETCH..EXEC window and the single EXEC cycle respectively.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            ir          <= '0;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            imm         <= '0;
            alu_op      <= '0;
            alu_src_imm <= 1'b0;
            we          <= 1'b0;
            busy        <= 1'b0;
            illegal     <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (opera) begin
                        state   <= FETCH;
                        busy    <= 1'b1;
                        illegal <= 1'b0;
                    end
                end
                FETCH: begin
                    ir    <= instr_data;
                    state <= DECODE;
                end
                DECODE: begin
                    if (dec_legal) begin
                        rs1         <= ir[19:15];
                        rs2         <= ir[24:20];
                        rd          <= ir[11:7];
                        imm         <= dec_imm;
                        alu_op      <= dec_op;
                        alu_src_imm <= dec_src_imm;
                    end else begin
                        rs1         <= '0;
                        rs2         <= '0;
                        rd          <= '0;
                        imm         <= '0;
                        alu_op      <= '0;
                        alu_src_imm <= 1'b0;
                    end
                    illegal <= ~dec_legal;
                    we      <= dec_legal;
                    state   <= EXEC;
                end
                EXEC: begin
                    we   <= 1'b0;
                    busy <= 1'b0;
                    pc   <= pc_next;
                    if (pc_next == PC_END) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calculadora_decode.sv
// Directed bench for calculadora_decode: main W=64 instance plus a W=32 instance
// and a PROG_LEN=2 instance, all fed from one shared ROM image.
module tb_calculadora_decode;

    logic        clock;
    logic        reset;
    logic        opera, opera32, opera2;
    logic [31:0] rom [0:255];

    logic [7:0]  addr, addr32, addr2;
    logic [31:0] data, data32, data2;
    logic [4:0]  rs1, rs2, rd, rs1_32, rs2_32, rd_32, rs1_2, rs2_2, rd_2;
    logic [63:0] imm, imm2;
    logic [31:0] imm32;
    logic [3:0]  alu_op, alu_op32, alu_op2;
    logic        src, src32, src2;
    logic        we, we32, we2, busy, busy32, busy2;
    logic        illegal, illegal32, illegal2, done, done32, done2;

    int          n_pass;
    int          n_total;
    int          cur;

    logic        m_busy, m_we, m_src, m_ill, m_done;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [3:0]  m_op;
    logic [63:0] m_imm;
    logic [7:0]  m_pc;

    calculadora_decode #(.W(64), .A(8), .PROG_LEN(16)) dut (
        .clock(clock), .reset(reset), .opera(opera), .instr_addr(addr), .instr_data(data),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_src_imm(src), .alu_op(alu_op),
        .we(we), .busy(busy), .illegal(illegal), .done(done)
    );

    calculadora_decode #(.W(32), .A(8), .PROG_LEN(16)) dut32 (
        .clock(clock), .reset(reset), .opera(opera32), .instr_addr(addr32), .instr_data(data32),
        .rs1(rs1_32), .rs2(rs2_32), .rd(rd_32), .imm(imm32), .alu_src_imm(src32), .alu_op(alu_op32),
        .we(we32), .busy(busy32), .illegal(illegal32), .done(done32)
    );

    calculadora_decode #(.W(64), .A(8), .PROG_LEN(2)) dut2 (
        .clock(clock), .reset(reset), .opera(opera2), .instr_addr(addr2), .instr_data(data2),
        .rs1(rs1_2), .rs2(rs2_2), .rd(rd_2), .imm(imm2), .alu_src_imm(src2), .alu_op(alu_op2),
        .we(we2), .busy(busy2), .illegal(illegal2), .done(done2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        data   <= rom[addr];
        data32 <= rom[addr32];
        data2  <= rom[addr2];
    end

    // Observation mux so one run task can serve any of the three instances.
    assign m_busy = (cur == 1) ? busy32 : (cur == 2) ? busy2 : busy;
    assign m_we   = (cur == 1) ? we32 : (cur == 2) ? we2 : we;
    assign m_src  = (cur == 1) ? src32 : (cur == 2) ? src2 : src;
    assign m_ill  = (cur == 1) ? illegal32 : (cur == 2) ? illegal2 : illegal;
    assign m_done = (cur == 1) ? done32 : (cur == 2) ? done2 : done;
    assign m_rs1  = (cur == 1) ? rs1_32 : (cur == 2) ? rs1_2 : rs1;
    assign m_rs2  = (cur == 1) ? rs2_32 : (cur == 2) ? rs2_2 : rs2;
    assign m_rd   = (cur == 1) ? rd_32 : (cur == 2) ? rd_2 : rd;
    assign m_op   = (cur == 1) ? alu_op32 : (cur == 2) ? alu_op2 : alu_op;
    assign m_imm  = (cur == 1) ? {32'h0, imm32} : (cur == 2) ? imm2 : imm;
    assign m_pc   = (cur == 1) ? addr32 : (cur == 2) ? addr2 : addr;

    task automatic set_opera(input logic v);
        case (cur)
            1:       opera32 = v;
            2:       opera2  = v;
            default: opera   = v;
        endcase
    endtask

    // One opera pulse; captures fields in the EXEC cycle and counts busy/we cycles.
    task automatic run_instr(output logic [63:0] c_imm, output logic [4:0] c_rs1,
                             output logic [4:0] c_rs2, output logic [4:0] c_rd,
                             output logic [3:0] c_op, output logic c_src, output logic c_ill,
                             output logic c_ill_fetch, output int busy_cnt, output int we_cnt);
        busy_cnt    = 0;
        we_cnt      = 0;
        c_imm       = '0;
        c_rs1       = '0;
        c_rs2       = '0;
        c_rd        = '0;
        c_op        = '0;
        c_src       = 1'b0;
        c_ill       = 1'b0;
        c_ill_fetch = 1'b0;
        @(negedge clock);
        set_opera(1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i == 0) begin
                set_opera(1'b0);
                c_ill_fetch = m_ill;
            end
            busy_cnt += int'(m_busy);
            we_cnt   += int'(m_we);
            if (i == 2) begin
                c_imm = m_imm;
                c_rs1 = m_rs1;
                c_rs2 = m_rs2;
                c_rd  = m_rd;
                c_op  = m_op;
                c_src = m_src;
                c_ill = m_ill;
            end
        end
    endtask

    logic [63:0] g_imm;
    logic [4:0]  g_rs1, g_rs2, g_rd;
    logic [3:0]  g_op;
    logic        g_src, g_ill, g_ill_fetch;
    int          g_busy, g_we;

    task automatic test_reset();
        cur   = 0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_total++; if (addr !== 8'd0) $display("[TB] FAIL reset_pc: got %0d expected 0", addr); else n_pass++;
        n_total++; if ({we, busy, done, illegal} !== 4'b0000) $display("[TB] FAIL reset_flags: got %b expected 0000", {we, busy, done, illegal}); else n_pass++;
        n_total++; if ({rd, rs1, rs2, alu_op, src} !== 20'h0) $display("[TB] FAIL reset_fields: got %h expected 0", {rd, rs1, rs2, alu_op, src}); else n_pass++;
        n_total++; if (imm !== 64'h0) $display("[TB] FAIL reset_imm: got %h expected 0", imm); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_addi();
        run_instr(g_imm, g_rs1, g_rs2, g_rd, g_op, g_src, g_ill, g_ill_fetch, g_busy, g_we);
        n_total++; if (g_busy !== 3) $display("[TB] FAIL addi_busy_cycles: got %0d expected 3", g_busy); else n_pass++;
        n_total++; if (g_we !== 1) $display("[TB] FAIL addi_we_pulses: got %0d expected 1", g_we); else n_pass++;
        n_total++; if ({g_rd, g_rs1, g_rs2} !== {5'd0, 5'd0, 5'd3}) $display("[TB] FAIL addi_regs: got %h expected %h", {g_rd, g_rs1, g_rs2}, {5'd0, 5'd0, 5'd3}); else n_pass++;
        n_total++; if (g_imm !== 64'd3) $display("[TB] FAIL addi_imm: got %h expected 3", g_imm); else n_pass++;
        n_total++; if ({g_op, g_src} !== {4'd0, 1'b1}) $display("[TB] FAIL addi_op_src: got %h expected 01", {g_op, g_src}); else n_pass++;
        n_total++; if ({addr, we} !== {8'd1, 1'b0}) $display("[TB] FAIL addi_after: got pc=%0d we=%b expected pc=1 we=0", addr, we); else n_pass++;
    endtask

    task automatic test_neg_imm();
        run_instr(g_imm, g_rs1, g_rs2, g_rd, g_op, g_src, g_ill, g_ill_fetch, g_busy, g_we);
        n_total++; if (g_imm !== 64'hFFFF_FFFF_FFFF_FFFF) $display("[TB] FAIL neg_imm: got %h expected ffffffffffffffff", g_imm); else n_pass++;
        n_total++; if ({g_rd, g_op} !== {5'd5, 4'd0}) $display("[TB] FAIL neg_rd_op: got %h expected %h", {g_rd, g_op}, {5'd5, 4'd0}); else n_pass++;
    endtask

    task automatic test_add_sub();
        run_instr(g_imm, g_rs1, g_rs2, g_rd, g_op, g_src, g_ill, g_ill_fetch, g_busy, g_we);
        n_total++; if ({g_rs1, g_rs2, g_rd} !== {5'd1, 5'd2, 5'd3}) $display("[TB] FAIL add_regs: got %h expected %h", {g_rs1, g_rs2, g_rd}, {5'd1, 5'd2, 5'd3}); else n_pass++;
        n_total++; if ({g_src, g_op, g_imm} !== {1'b0, 4'd0, 64'd0}) $display("[TB] FAIL add_src_op_imm: got %h expected 0", {g_src, g_op, g_imm}); else n_pass++;
        run_instr(g_imm, g_rs1, g_rs2, g_rd, g_op, g_src, g_ill, g_ill_fetch, g_busy, g_we);
        n_total++; if ({g_op, g_rd, g_rs1, g_rs2} !== {4'd1, 5'd4, 5'd1, 5'd1}) $display("[TB] FAIL sub_fields: got %h expected %h", {g_op, g_rd, g_rs1, g_rs2}, {4'd1, 5'd4, 5'd1, 5'd1}); else n_pass++;
        n_total++; if (g_we !== 1) $display("[TB] FAIL sub_we_pulses: got %0d expected 1", g_we); else n_pass++;
    endtask

    task automatic test_illegal();
        run_instr(g_imm, g_rs1, g_rs2, g_rd, g_op, g_src, g_ill, g_ill_fetch, g_busy, g_we);
        n_total++; if (g_ill !== 1'b1) $display("[TB] FAIL ecall_illegal: got %b expected 1", g_ill); else n_pass++;
        n_total++; if (g_we !== 0) $display("[TB] FAIL ecall_we_pulses: got %0d expected 0", g_we); else n_pass++;
        n_total++; if ({g_rd, g_rs1, g_rs2, g_op, g_imm} !== '0) $display("[TB] FAIL ecall_fields_zero: got %h expected 0", {g_rd, g_rs1, g_rs2, g_op, g_imm}); else n_pass++;
        n_total++; if ({addr, illegal} !== {8'd5, 1'b1}) $display("[TB] FAIL ecall_after: got pc=%0d illegal=%b expected pc=5 illegal=1", addr, illegal); else n_pass++;
    endtask

    task automatic test_shift_imm();
        run_instr(g_imm, g_rs1, g_rs2, g_rd, g_op, g_src, g_ill, g_ill_fetch, g_busy, g_we);
        n_total++; if (g_ill_fetch !== 1'b0) $display("[TB] FAIL illegal_cleared_on_accept: got %b expected 0", g_ill_fetch); else n_pass++;
        n_total++; if ({g_imm, g_op, g_src} !== {64'd4, 4'd7, 1'b1}) $display("[TB] FAIL srai_imm_op: got imm=%h op=%0d src=%b expected imm=4 op=7 src=1", g_imm, g_op, g_src); else n_pass++;
        n_total++; if ({g_rd, g_rs1} !== {5'd6, 5'd7}) $display("[TB] FAIL srai_regs: got %h expected %h", {g_rd, g_rs1}, {5'd6, 5'd7}); else n_pass++;
        run_instr(g_imm, g_rs1, g_rs2, g_rd, g_op, g_src, g_ill, g_ill_fetch, g_busy, g_we);
        n_total++; if ({g_ill, g_we[0]} !== 2'b10) $display("[TB] FAIL bad_f7_shift: got ill=%b we=%0d expected ill=1 we=0", g_ill, g_we); else n_pass++;
    endtask

    task automatic test_andi_sltu();
        run_instr(g_imm, g_rs1, g_rs2, g_rd, g_op, g_src, g_ill, g_ill_fetch, g_busy, g_we);
        n_total++; if ({g_imm, g_op} !== {64'hFFFF_FFFF_FFFF_FFF0, 4'd9}) $display("[TB] FAIL andi: got imm=%h op=%0d expected imm=fffffffffffffff0 op=9", g_imm, g_op); else n_pass++;
        n_total++; if ({g_rd, g_rs1} !== {5'd8, 5'd9}) $display("[TB] FAIL andi_regs: got %h expected %h", {g_rd, g_rs1}, {5'd8, 5'd9}); else n_pass++;
        run_instr(g_imm, g_rs1, g_rs2, g_rd, g_op, g_src, g_ill, g_ill_fetch, g_busy, g_we);
        n_total++; if ({g_op, g_src, g_rs1, g_rs2, g_rd} !== {4'd4, 1'b0, 5'd11, 5'd12, 5'd10}) $display("[TB] FAIL sltu: got %h expected %h", {g_op, g_src, g_rs1, g_rs2, g_rd}, {4'd4, 1'b0, 5'd11, 5'd12, 5'd10}); else n_pass++;
        run_instr(g_imm, g_rs1, g_rs2, g_rd, g_op, g_src, g_ill, g_ill_fetch, g_busy, g_we);
        n_total++; if ({g_ill, g_we[0]} !== 2'b10) $display("[TB] FAIL op_alt_sll_illegal: got ill=%b we=%0d expected ill=1 we=0", g_ill, g_we); else n_pass++;
        n_total++; if (addr !== 8'd10) $display("[TB] FAIL pc_after_illegal: got %0d expected 10", addr); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int we_cnt;
        we_cnt = 0;
        @(negedge clock);
        opera = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            we_cnt += int'(we);
            if (i == 9) opera = 1'b0;
        end
        n_total++; if (we_cnt !== 3) $display("[TB] FAIL held_opera_we_pulses: got %0d expected 3", we_cnt); else n_pass++;
        n_total++; if (addr !== 8'd13) $display("[TB] FAIL held_opera_pc: got %0d expected 13", addr); else n_pass++;
        n_total++; if ({rd, imm} !== {5'd3, 64'd3}) $display("[TB] FAIL held_last_fields: got rd=%0d imm=%h expected rd=3 imm=3", rd, imm); else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        opera = 1'b1;
        @(negedge clock);
        opera = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_total++; if ({addr, we, busy} !== {8'd0, 1'b0, 1'b0}) $display("[TB] FAIL mid_reset_state: got pc=%0d we=%b busy=%b expected 0 0 0", addr, we, busy); else n_pass++;
        n_total++; if ({rd, rs1, rs2, imm, alu_op, src} !== '0) $display("[TB] FAIL mid_reset_fields: got %h expected 0", {rd, rs1, rs2, imm, alu_op, src}); else n_pass++;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_total++; if ({we, busy} !== 2'b00) $display("[TB] FAIL mid_reset_quiet: got we=%b busy=%b expected 0 0", we, busy); else n_pass++;
    endtask

    task automatic test_w32();
        cur = 1;
        run_instr(g_imm, g_rs1, g_rs2, g_rd, g_op, g_src, g_ill, g_ill_fetch, g_busy, g_we);
        run_instr(g_imm, g_rs1, g_rs2, g_rd, g_op, g_src, g_ill, g_ill_fetch, g_busy, g_we);
        n_total++; if (g_imm !== 64'h0000_0000_FFFF_FFFF) $display("[TB] FAIL w32_neg_imm: got %h expected ffffffff", g_imm); else n_pass++;
        n_total++; if ({g_rd, g_we[0]} !== {5'd5, 1'b1}) $display("[TB] FAIL w32_rd_we: got rd=%0d we=%0d expected 5 1", g_rd, g_we); else n_pass++;
    endtask

    task automatic test_done();
        cur = 2;
        run_instr(g_imm, g_rs1, g_rs2, g_rd, g_op, g_src, g_ill, g_ill_fetch, g_busy, g_we);
        n_total++; if ({m_done, m_pc} !== {1'b0, 8'd1}) $display("[TB] FAIL done_after_first: got done=%b pc=%0d expected 0 1", m_done, m_pc); else n_pass++;
        run_instr(g_imm, g_rs1, g_rs2, g_rd, g_op, g_src, g_ill, g_ill_fetch, g_busy, g_we);
        n_total++; if ({m_done, m_pc} !== {1'b1, 8'd2}) $display("[TB] FAIL done_after_second: got done=%b pc=%0d expected 1 2", m_done, m_pc); else n_pass++;
        run_instr(g_imm, g_rs1, g_rs2, g_rd, g_op, g_src, g_ill, g_ill_fetch, g_busy, g_we);
        n_total++; if ({g_busy, g_we} !== {32'd0, 32'd0}) $display("[TB] FAIL done_ignores_opera: got busy=%0d we=%0d expected 0 0", g_busy, g_we); else n_pass++;
        n_total++; if ({m_done, m_pc} !== {1'b1, 8'd2}) $display("[TB] FAIL done_holds: got done=%b pc=%0d expected 1 2", m_done, m_pc); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        cur     = 0;
        opera   = 1'b0;
        opera32 = 1'b0;
        opera2  = 1'b0;
        reset   = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = 32'h0000_0013;
        rom[0]  = 32'h0030_0013;
        rom[1]  = 32'hFFF0_0293;
        rom[2]  = 32'h0020_81B3;
        rom[3]  = 32'h4010_8233;
        rom[4]  = 32'h0000_0073;
        rom[5]  = 32'h4043_D313;
        rom[6]  = 32'h0203_D313;
        rom[7]  = 32'hFF04_F413;
        rom[8]  = 32'h00C5_B533;
        rom[9]  = 32'h4000_1033;
        rom[10] = 32'h0010_0093;
        rom[11] = 32'h0020_0113;
        rom[12] = 32'h0030_0193;
        rom[13] = 32'h0050_0213;

        test_reset();
        test_addi();
        test_neg_imm();
        test_add_sub();
        test_illegal();
        test_shift_imm();
        test_andi_sltu();
        test_back_to_back();
        test_reset_mid();
        test_w32();
        test_done();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/calculadora_decode.md
Name: calculadora_decode

Overview:
- Fetch/decode front end that feeds the calculator datapath (register file + ALU).
- Each `opera` pulse makes the block fetch one 32-bit RV32I-style instruction from a synchronous instruction ROM at the program counter (PC).
- It decodes the instruction into register indices, a sign-extended immediate and an ALU operation code, then issues exactly one write-enable pulse to the register file.
- It supports the OP-IMM (0010011) and OP (0110011) instruction classes only.

Parameters:
- W, 64, datapath width of `imm`; W >= 12.
- A, 8, PC / ROM address width.
- PROG_LEN, 16, number of instructions in the program; 1 <= PROG_LEN <= 2^A.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opera  in  1  execute-one-instruction request; sampled only in IDLE
- instr_addr  out  A  ROM address; always equals PC
- instr_data  in  32  ROM word; valid one cycle after instr_addr
- rs1  out  5  source register 1 index
- rs2  out  5  source register 2 index
- rd  out  5  destination register index
- imm  out  W  sign-extended immediate, or zero-extended shamt for shift-immediates
- alu_src_imm  out  1  1 = ALU operand B is imm; 0 = operand B is RF[rs2]
- alu_op  out  4  ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9
- we  out  1  register-file write enable; one-cycle pulse
- busy  out  1  high in FETCH, DECODE and EXEC
- illegal  out  1  last decoded instruction was unsupported
- done  out  1  program finished

Behaviour:
- Reset (any state, including mid-instruction):
  - State goes to IDLE and PC to 0.
  - IR, rs1, rs2, rd, imm, alu_op, alu_src_imm, we, illegal and done all go to 0.
- States: IDLE, FETCH, DECODE, EXEC, DONE.
- IDLE:
  - With opera=1 at the edge, go to FETCH; illegal clears to 0.
  - With opera=0, stay in IDLE.
- FETCH: wait for the ROM; at the edge, IR <= instr_data and go to DECODE.
- DECODE: at the edge, register all decoded fields from IR and go to EXEC.
- EXEC:
  - we = 1 for exactly this cycle, if and only if the instruction is legal.
  - At the edge, PC <= PC+1.
  - If PC+1 == PROG_LEN, go to DONE; otherwise go to IDLE.
- DONE: done=1, busy=0; opera is ignored. Leave only via reset.
- Latency: opera sampled at edge 0 → IR loaded at edge 1 → fields valid after edge 2 → register-file write committed at edge 3. Opera-to-opera spacing is at least 4 cycles.
- opera while busy: ignored, not queued. A level held high through EXEC re-triggers in the next IDLE cycle.
- Field extraction:
  - rd=IR[11:7], rs1=IR[19:15], rs2=IR[24:20], funct3=IR[14:12], funct7=IR[31:25].
- OP-IMM (alu_src_imm=1):
  - imm = sign-extend IR[31:20] to W.
  - funct3 000 ADDI→ADD, 010→SLT, 011→SLTU, 100→XOR, 110→OR, 111→AND.
  - 001 SLLI: funct7 must be 0000000; op SLL.
  - 101: funct7 0000000 → SRL, 0100000 → SRA; any other funct7 is illegal.
  - Shift immediates: imm = zero-extend IR[24:20].
- OP (alu_src_imm=0, imm=0):
  - funct7 0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7 0100000: only 000 SUB and 101 SRA are legal.
- Illegal instruction (any other opcode/funct combination):
  - illegal=1, we stays 0, PC still advances.
  - Other decoded outputs are 0; illegal is held until the next accepted opera.
- rd = 0 is an ordinary register: we is asserted normally (no x0 hardwiring).
- Decoded outputs hold their values from DECODE until the next DECODE or reset.
- PC arithmetic is modulo 2^A; with PROG_LEN = 2^A, DONE is entered when PC wraps to 0.

Test Plan:
- Reset, then ROM[0]=0x00300013 (addi x0,x0,3), opera pulse → busy for 3 cycles. In EXEC: we=1, rd=0, rs1=0, imm=3, alu_op=0, alu_src_imm=1. Afterwards PC=1, we=0.
- ROM[1]=0xFFF00293 (addi x5,x0,-1) → imm=0xFFFF_FFFF_FFFF_FFFF (W=64), rd=5, alu_op=0. Rerun with W=32 → imm=0xFFFF_FFFF.
- ROM[2]=0x002081B3 (add x3,x1,x2) → rs1=1, rs2=2, rd=3, alu_src_imm=0, alu_op=0. ROM[3]=0x40108233 (sub x4,x1,x1) → alu_op=1, rd=4.
- ROM[4]=0x00000073 (ecall) → illegal=1, we never asserted, PC becomes 5. Next opera clears illegal at the accept edge.
- opera held high for 10 cycles → exactly 3 instructions executed (accept edges 0, 4, 8), one we pulse each. Reset asserted during DECODE → next cycle state IDLE, PC=0, we=0, outputs 0.
- PROG_LEN=2: two opera pulses → done=1 after the second EXEC. A third opera → no busy, no we, PC stays 2.
